// File: rtl/accumulator_drain_pkg.sv
// -----------------------------------------------------------------------------
// tpu_package
// Shared constants and types for the accumulator drain path.
//   MUL_SIZE      : systolic array width = number of result lanes
//   RES_WIDTH     : MSB index of one result lane (lane is RES_WIDTH+1 bits,
//                   two's complement)
//   ACC_ROWS      : number of accumulator storage rows (address wraps here)
//   drain_state_t : drain controller FSM states
// -----------------------------------------------------------------------------
package tpu_package;

    localparam int MUL_SIZE  = 32;
    localparam int RES_WIDTH = 31;
    localparam int ACC_ROWS  = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } drain_state_t;

endpackage

// File: rtl/accumulator_drain_deskew_lane.sv
// -----------------------------------------------------------------------------
// deskew_lane
// Single-lane delay line of DEPTH beats. The line advances only when shift_i
// is high, so idle cycles between returned reads do not disturb alignment.
// DEPTH=0 degenerates to a wire.
// Ports:
//   clk_i   : clock
//   rst_i   : asynchronous active-low reset, clears the line
//   shift_i : advance the line by one beat
//   clr_i   : synchronous clear of the line
//   data_i  : lane input
//   data_o  : lane input delayed by DEPTH beats
// -----------------------------------------------------------------------------
module deskew_lane #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             shift_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_ctrl;
            assign unused_ctrl = ^{clk_i, rst_i, shift_i, clr_i};
            assign data_o      = data_i;
        end else begin : g_line
            logic [WIDTH-1:0] taps [DEPTH];

            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
                end else if (clr_i) begin
                    for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
                end else if (shift_i) begin
                    taps[0] <= data_i;
                    for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
                end
            end

            assign data_o = taps[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/accumulator_drain.sv
// -----------------------------------------------------------------------------
// accumulator_drain
// Read-side controller for the accumulator. Issues diagonal reads, removes the
// per-lane storage skew and hands row-aligned vectors to the unified-buffer
// writer through a 2-entry FIFO with valid/ready backpressure.
// Optional feature macro: ACC_DRAIN_RELU_EN (ReLU applied at the FIFO output;
// latency unchanged).
// Ports:
//   clk_i, rst_i   : clock, asynchronous active-low reset
//   start_i        : one-cycle drain request, sampled in IDLE only
//   base_addr_i    : accumulator address of row 0 (bits [6:0] used)
//   rows_i         : rows to drain, values above 128 saturate to 128
//   acc_rd_en_o    : accumulator read enable
//   acc_addr_rd_o  : accumulator read address (bits [9:7] always 0)
//   acc_data_i     : read data, valid one cycle after acc_rd_en_o
//   row_o          : de-skewed row at the FIFO head
//   row_idx_o      : 0-based index of the row on row_o
//   row_valid_o    : row_o holds a row
//   row_ready_i    : downstream accepts row_o
//   busy_o         : controller not idle (accumulator add_i held low)
//   done_o         : one-cycle pulse after the last row is accepted
// -----------------------------------------------------------------------------
module accumulator_drain
    import tpu_package::*;
(
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               start_i,
    input  logic [9:0]                         base_addr_i,
    input  logic [7:0]                         rows_i,
    output logic                               acc_rd_en_o,
    output logic [9:0]                         acc_addr_rd_o,
    input  logic [MUL_SIZE-1:0][RES_WIDTH:0]   acc_data_i,
    output logic [MUL_SIZE-1:0][RES_WIDTH:0]   row_o,
    output logic [6:0]                         row_idx_o,
    output logic                               row_valid_o,
    input  logic                               row_ready_i,
    output logic                               busy_o,
    output logic                               done_o
);

    localparam logic [7:0] FILL = 8'(MUL_SIZE - 1);

    function automatic logic [7:0] sat_rows(input logic [7:0] r);
        return (r > 8'(ACC_ROWS)) ? 8'(ACC_ROWS) : r;
    endfunction

    function automatic logic [RES_WIDTH:0] relu(input logic signed [RES_WIDTH:0] v);
        return v[RES_WIDTH] ? '0 : v;
    endfunction

    drain_state_t state;
    logic [6:0]   addr_q;
    logic [7:0]   rows_q;
    logic [7:0]   issue_cnt;
    logic [7:0]   beat_cnt;
    logic [7:0]   total_reads;

    logic         beat_vld_p1;
    logic [MUL_SIZE-1:0][RES_WIDTH:0] aligned_p1;

    logic [MUL_SIZE-1:0][RES_WIDTH:0] fifo_mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   fifo_cnt;
    logic [6:0]   out_idx;

    logic         push;
    logic         pop;
    logic [1:0]   occ_after_pop;
    logic [2:0]   credit_use;
    logic         credit_ok;
    logic         issue_fill;
    logic         rd_en;
    logic         last_issue;
    logic         clr_lanes;
    logic         unused_base;

    assign unused_base = ^base_addr_i[9:7];

    // Beat j of a job carries lane k of row j-k, so the first FILL beats hold
    // no complete row and never enter the FIFO.
    assign total_reads   = rows_q + FILL;
    assign push          = beat_vld_p1 && (beat_cnt >= FILL);
    assign pop           = row_valid_o && row_ready_i;
    assign issue_fill    = issue_cnt < FILL;

    // Credit counts the FIFO after this cycle's pop plus the row landing this
    // cycle; a new read lands next cycle, so the FIFO can never overflow while
    // a full-rate stream with ready high still gets a read every cycle.
    assign occ_after_pop = fifo_cnt - {1'b0, pop};
    assign credit_use    = {1'b0, occ_after_pop} + {2'b00, push};
    assign credit_ok     = credit_use < 3'd2;

    assign rd_en         = (state == ISSUE) && (issue_fill || credit_ok);
    assign last_issue    = rd_en && (issue_cnt == total_reads - 8'd1);
    assign clr_lanes     = (state == DONE);

    assign acc_rd_en_o   = rd_en;
    assign acc_addr_rd_o = {3'b000, addr_q};

    // Control FSM
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            addr_q    <= '0;
            rows_q    <= '0;
            issue_cnt <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        addr_q    <= base_addr_i[6:0];
                        rows_q    <= sat_rows(rows_i);
                        issue_cnt <= '0;
                        busy_o    <= 1'b1;
                        state     <= (rows_i == 8'd0) ? DONE : ISSUE;
                    end
                end
                ISSUE: begin
                    if (rd_en) begin
                        addr_q    <= addr_q + 7'd1;
                        issue_cnt <= issue_cnt + 8'd1;
                        if (last_issue) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Leave on the edge that retires the final row so done_o
                    // follows the last handshake by exactly one cycle.
                    if (!beat_vld_p1 && (fifo_cnt == {1'b0, pop})) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                    end
                end
                DONE: begin
                    // An empty job never passes DRAIN, so its pulse is raised here.
                    done_o <= (rows_q == 8'd0);
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage p1: returned beat shifts the lane delay lines
    generate
        for (genvar k = 0; k < MUL_SIZE; k++) begin : g_lane
            deskew_lane #(
                .WIDTH (RES_WIDTH + 1),
                .DEPTH (MUL_SIZE - 1 - k)
            ) u_deskew (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .shift_i (beat_vld_p1),
                .clr_i   (clr_lanes),
                .data_i  (acc_data_i[k]),
                .data_o  (aligned_p1[k])
            );
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            beat_vld_p1 <= 1'b0;
            beat_cnt    <= '0;
        end else begin
            beat_vld_p1 <= rd_en;
            if ((state == IDLE) && start_i) beat_cnt <= '0;
            else if (beat_vld_p1)           beat_cnt <= beat_cnt + 8'd1;
        end
    end

    // Stage p2: aligned rows queue for the output handshake
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_cnt    <= '0;
            out_idx     <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= aligned_p1;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
            if ((state == IDLE) && start_i) out_idx <= '0;
            else if (pop)                   out_idx <= out_idx + 7'd1;
        end
    end

    assign row_valid_o = (fifo_cnt != 2'd0);
    assign row_idx_o   = out_idx;

    always_comb begin
        row_o = '0;
        for (int k = 0; k < MUL_SIZE; k++) begin
`ifdef ACC_DRAIN_RELU_EN
            row_o[k] = relu(fifo_mem[rd_ptr][k]);
`else
            row_o[k] = fifo_mem[rd_ptr][k];
`endif
        end
    end

endmodule

// File: tb/tb_accumulator_drain.sv
// -----------------------------------------------------------------------------
// tb_accumulator_drain
// Bench for accumulator_drain: a skewed accumulator memory model answers the
// reads, and a scoreboard of expected rows (taken straight from storage rows)
// is compared against every accepted output row. Honors ACC_DRAIN_RELU_EN.
// -----------------------------------------------------------------------------
module tb_accumulator_drain;
    import tpu_package::*;

    typedef logic [MUL_SIZE-1:0][RES_WIDTH:0] row_t;

    logic        clk;
    logic        rst_i;
    logic        start_i;
    logic [9:0]  base_addr_i;
    logic [7:0]  rows_i;
    logic        acc_rd_en_o;
    logic [9:0]  acc_addr_rd_o;
    row_t        acc_data_i;
    row_t        row_o;
    logic [6:0]  row_idx_o;
    logic        row_valid_o;
    logic        row_ready_i;
    logic        busy_o;
    logic        done_o;

    accumulator_drain dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .base_addr_i   (base_addr_i),
        .rows_i        (rows_i),
        .acc_rd_en_o   (acc_rd_en_o),
        .acc_addr_rd_o (acc_addr_rd_o),
        .acc_data_i    (acc_data_i),
        .row_o         (row_o),
        .row_idx_o     (row_idx_o),
        .row_valid_o   (row_valid_o),
        .row_ready_i   (row_ready_i),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_vec  = 0;
    int   n_miss = 0;
    int   cyc    = 0;

    row_t storage [ACC_ROWS];
    row_t got_rows [ACC_ROWS];
    row_t exp_q [$];

    int   t0, exp_base, exp_total, n_reads, n_pop;
    int   first_rd, first_valid, done_cyc, last_addr;
    bit   exp_active = 0;
    int   ready_mode = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_row(input string nm, input row_t act, input row_t exp);
        int bad;
        bad = -1;
        for (int k = 0; k < MUL_SIZE; k++)
            if (act[k] !== exp[k] && bad < 0) bad = k;
        n_vec++;
        if (bad >= 0) begin
            n_miss++;
            $display("FAIL %s lane %0d: got %0h expected %0h", nm, bad, act[bad], exp[bad]);
        end
    endtask

    function automatic row_t model_row(input row_t s);
        row_t r;
        r = s;
`ifdef ACC_DRAIN_RELU_EN
        for (int k = 0; k < MUL_SIZE; k++)
            if (s[k][RES_WIDTH]) r[k] = '0;
`endif
        return r;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Accumulator model: address a returns lane k of storage row a-k, one cycle later.
    initial begin
        bit en;
        int a;
        acc_data_i = '0;
        forever begin
            @(negedge clk);
            en = acc_rd_en_o;
            a  = int'(acc_addr_rd_o[6:0]);
            @(posedge clk);
            #1;
            if (en)
                for (int k = 0; k < MUL_SIZE; k++)
                    acc_data_i[k] = storage[(a - k + ACC_ROWS) % ACC_ROWS][k];
        end
    end

    initial begin
        row_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       row_ready_i = 1'b1;
                1:       row_ready_i = ~row_ready_i;
                default: row_ready_i = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Compare process
    initial begin
        bit   stall_prev;
        row_t prev_row;
        logic [6:0] prev_idx;
        row_t exp_row;
        int   rel, buffered;
        stall_prev = 0;
        prev_row   = '0;
        prev_idx   = '0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                rel = cyc - t0;
                if (acc_rd_en_o) begin
                    if (first_rd < 0) first_rd = rel;
                    check("rd_in_job", 64'(exp_active && (n_reads < exp_total)), 64'd1);
                    check("rd_addr", 64'(acc_addr_rd_o), 64'((exp_base + n_reads) % ACC_ROWS));
                    last_addr = int'(acc_addr_rd_o);
                    n_reads++;
                end
                if (stall_prev) begin
                    check("valid_held", 64'(row_valid_o), 64'd1);
                    check("row_stable", 64'(row_o == prev_row), 64'd1);
                    check("idx_stable", 64'(row_idx_o), 64'(prev_idx));
                end
                if (row_valid_o) begin
                    if (first_valid < 0) first_valid = rel;
                    if (row_ready_i) begin
                        check("row_expected", 64'(exp_q.size() != 0), 64'd1);
                        if (exp_q.size() != 0) begin
                            exp_row = exp_q.pop_front();
                            check_row("row_data", row_o, exp_row);
                            check("row_idx", 64'(row_idx_o), 64'(n_pop % ACC_ROWS));
                            got_rows[n_pop % ACC_ROWS] = row_o;
                            n_pop++;
                        end
                    end
                end
                stall_prev = row_valid_o && !row_ready_i;
                prev_row   = row_o;
                prev_idx   = row_idx_o;
                if (exp_active) begin
                    buffered = ((n_reads > MUL_SIZE - 1) ? n_reads - (MUL_SIZE - 1) : 0) - n_pop;
                    check("buffered_le_2", 64'(buffered <= 2), 64'd1);
                end
                if (done_o) begin
                    check("done_legal", 64'(exp_active && exp_q.size() == 0 && n_reads == exp_total), 64'd1);
                    done_cyc   = rel;
                    exp_active = 0;
                end
            end else begin
                stall_prev = 0;
            end
        end
    end

    task automatic start_job(input int base, input int rows, input int rmode);
        int eff;
        @(posedge clk);
        #1;
        eff = (rows > ACC_ROWS) ? ACC_ROWS : rows;
        exp_q.delete();
        for (int r = 0; r < eff; r++)
            exp_q.push_back(model_row(storage[(base + r) % ACC_ROWS]));
        exp_base    = base % ACC_ROWS;
        exp_total   = (eff == 0) ? 0 : eff + MUL_SIZE - 1;
        n_reads     = 0;
        n_pop       = 0;
        first_rd    = -1;
        first_valid = -1;
        done_cyc    = -1;
        last_addr   = -1;
        ready_mode  = rmode;
        exp_active  = 1;
        t0          = cyc;
        start_i     = 1'b1;
        base_addr_i = 10'(base);
        rows_i      = 8'(rows);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        check("busy_after_start", 64'(busy_o), 64'd1);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (exp_active && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("job_timeout", 64'(exp_active), 64'd0);
        exp_active = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_en"},  64'(acc_rd_en_o),   64'd0);
        check({tag, "_addr"},   64'(acc_addr_rd_o), 64'd0);
        check({tag, "_row"},    64'(row_o != '0),   64'd0);
        check({tag, "_idx"},    64'(row_idx_o),     64'd0);
        check({tag, "_valid"},  64'(row_valid_o),   64'd0);
        check({tag, "_busy"},   64'(busy_o),        64'd0);
        check({tag, "_done"},   64'(done_o),        64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rows_tab [6] = '{1, 2, 128, 200, 57, 99};
        row_t tmp;
        t0 = 0;
        rst_i = 1'b0;
        start_i = 1'b0;
        base_addr_i = '0;
        rows_i = '0;
        for (int r = 0; r < ACC_ROWS; r++)
            for (int k = 0; k < MUL_SIZE; k++)
                storage[r][k] = (RES_WIDTH + 1)'(r * 100 + k);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst_i = 1'b1;

        // Full-rate drain of 32 rows from base 0
        start_job(0, 32, 0);
        wait_done(400);
        check("t1_first_rd",    64'(first_rd),    64'd1);
        check("t1_first_valid", 64'(first_valid), 64'd34);
        check("t1_done_cycle",  64'(done_cyc),    64'd66);
        check("t1_reads",       64'(n_reads),     64'd63);
        check("t1_rows",        64'(n_pop),       64'd32);
        tmp = got_rows[5];
        check("t1_row5_lane3",  64'(tmp[3]),      64'd503);
        tmp = got_rows[31];
        check("t1_row31_lane31", 64'(tmp[31]),    64'd3131);

        // Empty job
        start_job(7, 0, 0);
        wait_done(20);
        check("t2_done_cycle", 64'(done_cyc), 64'd2);
        check("t2_reads",      64'(n_reads),  64'd0);
        check("t2_valids",     64'(first_valid < 0), 64'd1);

        // Wrapping addresses
        for (int r = 0; r < ACC_ROWS; r++)
            for (int k = 0; k < MUL_SIZE; k++)
                storage[r][k] = (RES_WIDTH + 1)'($urandom);
        start_job(120, 16, 0);
        wait_done(400);
        check("t3_reads",     64'(n_reads),   64'd47);
        check("t3_last_addr", 64'(last_addr), 64'd38);
        check("t3_rows",      64'(n_pop),     64'd16);

        // Toggling ready, with a start pulse that must be ignored mid-job
        start_job(3, 8, 1);
        repeat (3) @(posedge clk);
        #1;
        start_i = 1'b1;
        base_addr_i = 10'd50;
        rows_i = 8'd3;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        wait_done(400);
        check("t4_rows", 64'(n_pop), 64'd8);

        // Reset in the middle of a job
        start_job(0, 32, 0);
        repeat (9) @(posedge clk);
        #1;
        rst_i = 1'b0;
        exp_active = 0;
        exp_q.delete();
        @(negedge clk);
        check_all_zero("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b1;
        start_job(10, 32, 2);
        wait_done(1000);
        check("t5_rows", 64'(n_pop), 64'd32);

        // Randomised jobs
        for (int j = 0; j < 6; j++) begin
            start_job(int'($urandom_range(0, 1023)), rows_tab[j], 2);
            wait_done(2000);
            check("rand_rows", 64'(n_pop), 64'((rows_tab[j] > ACC_ROWS) ? ACC_ROWS : rows_tab[j]));
        end

        // Sign handling of individual lanes
        tmp = storage[0];
        tmp[0] = (RES_WIDTH + 1)'(-5);
        tmp[1] = (RES_WIDTH + 1)'(7);
        storage[0] = tmp;
        start_job(0, 1, 0);
        wait_done(200);
        tmp = got_rows[0];
`ifdef ACC_DRAIN_RELU_EN
        check("t6_neg_lane", 64'(tmp[0]), 64'd0);
`else
        check("t6_neg_lane", 64'(tmp[0]), 64'(32'hFFFF_FFFB));
`endif
        check("t6_pos_lane", 64'(tmp[1]), 64'd7);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
